// File: rtl/alarm_set_ctrl.sv
// Alarm-setting controller: debounces mode/sel/inc keys, runs the set-mode FSM and edits HH:MM in BCD.
// Define AUTO_REPEAT_EN to build auto-repeat of the increment key while a set state is active.
module alarm_set_ctrl #(
    parameter int DB_CYCLES      = 20,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int REPEAT_DLY     = 500,
    parameter int REPEAT_PER     = 100
) (
    input  logic       fs,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_sel,
    input  logic       key_inc,
    output logic [1:0] mk,
    output logic [1:0] k1,
    output logic [3:0] c,
    output logic [3:0] d,
    output logic [3:0] e,
    output logic [3:0] f,
    output logic       alarm_on
);
    // state  | meaning
    // S_IDLE | committed alarm shown; inc toggles alarm_on, sel ignored
    // S_MIN  | editing shadow minutes
    // S_HOUR | editing shadow hours
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MIN  = 2'd1,
        S_HOUR = 2'd2
    } state_t;

    localparam int K_MODE = 0;
    localparam int K_SEL  = 1;
    localparam int K_INC  = 2;

    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DB_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]            key_raw;
    logic [2:0]            sync1_q;
    logic [2:0]            sync2_q;
    logic [2:0]            db_q, db_d;
    logic [2:0]            db_prev_q;
    logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [2:0]            press;
    logic                  rep_pulse;

    state_t                state_q, state_d;
    logic [7:0]            sh_min_q, sh_min_d;
    logic [7:0]            sh_hr_q, sh_hr_d;
    logic [7:0]            cm_min_q, cm_min_d;
    logic [7:0]            cm_hr_q, cm_hr_d;
    logic                  on_q, on_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [1:0]            mk_q, mk_d;
    logic [1:0]            k1_q, k1_d;
    logic [15:0]           disp_q, disp_d;
    logic                  inc_p;

    assign key_raw = {key_inc, key_sel, key_mode};

    // Debounce down-counter sits at its load value while the synchronised level matches.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = DB_LOAD;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == '0) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] - DB_W'(1);
                end
            end
        end
    end

    assign press = db_q & ~db_prev_q;

    always_ff @(posedge fs or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            db_cnt_q  <= {3{DB_LOAD}};
        end else begin
            sync1_q   <= key_raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            db_cnt_q  <= db_cnt_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;
    localparam logic [RP_W-1:0] RP_DLY_LOAD = RP_W'(REPEAT_DLY - 1);
    localparam logic [RP_W-1:0] RP_PER_LOAD = RP_W'(REPEAT_PER - 1);

    logic            rep_act_q, rep_act_d;
    logic [RP_W-1:0] rep_tmr_q, rep_tmr_d;

    assign rep_pulse = rep_act_q && db_q[K_INC] && (state_q != S_IDLE) && (rep_tmr_q == '0);

    // Armed only by an inc press that the set-state FSM actually consumes.
    always_comb begin
        rep_act_d = rep_act_q;
        rep_tmr_d = rep_tmr_q;
        if (!db_q[K_INC] || state_q == S_IDLE) begin
            rep_act_d = 1'b0;
        end else if (press[K_INC] && !press[K_MODE] && !press[K_SEL]) begin
            rep_act_d = 1'b1;
            rep_tmr_d = RP_DLY_LOAD;
        end else if (rep_pulse) begin
            rep_tmr_d = RP_PER_LOAD;
        end else if (rep_act_q) begin
            rep_tmr_d = rep_tmr_q - RP_W'(1);
        end
    end

    always_ff @(posedge fs or negedge rst_n) begin
        if (!rst_n) begin
            rep_act_q <= 1'b0;
            rep_tmr_q <= '0;
        end else begin
            rep_act_q <= rep_act_d;
            rep_tmr_q <= rep_tmr_d;
        end
    end
`else
    assign rep_pulse = 1'b0;
`endif

    function automatic logic [7:0] bcd2_inc(input logic [7:0] val, input logic [7:0] top);
        logic [7:0] r;
        if (val == top) begin
            r = 8'h00;
        end else if (val[3:0] == 4'd9) begin
            r = {val[7:4] + 4'd1, 4'd0};
        end else begin
            r = {val[7:4], val[3:0] + 4'd1};
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        sh_min_d = sh_min_q;
        sh_hr_d  = sh_hr_q;
        cm_min_d = cm_min_q;
        cm_hr_d  = cm_hr_q;
        on_d     = on_q;
        to_cnt_d = TO_LOAD;
        inc_p    = press[K_INC] | rep_pulse;

        case (state_q)
            S_IDLE: begin
                if (press[K_MODE]) begin
                    state_d  = S_MIN;
                    sh_min_d = cm_min_q;
                    sh_hr_d  = cm_hr_q;
                end else if (press[K_INC] && !press[K_SEL]) begin
                    on_d = ~on_q;
                end
            end
            S_MIN, S_HOUR: begin
                if (press[K_MODE]) begin
                    state_d  = S_IDLE;
                    cm_min_d = sh_min_q;
                    cm_hr_d  = sh_hr_q;
                end else if (press[K_SEL]) begin
                    state_d = (state_q == S_MIN) ? S_HOUR : S_MIN;
                end else if (inc_p) begin
                    if (state_q == S_MIN) begin
                        sh_min_d = bcd2_inc(sh_min_q, 8'h59);
                    end else begin
                        sh_hr_d = bcd2_inc(sh_hr_q, 8'h23);
                    end
                end else if (to_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q - TO_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from next-state values so they move on the acting edge.
        mk_d   = (state_d == S_IDLE) ? 2'b00 : 2'b11;
        k1_d   = (state_d == S_HOUR) ? 2'b01 : 2'b00;
        disp_d = (state_d == S_IDLE) ? {cm_hr_d, cm_min_d} : {sh_hr_d, sh_min_d};
    end

    always_ff @(posedge fs or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sh_min_q <= '0;
            sh_hr_q  <= '0;
            cm_min_q <= '0;
            cm_hr_q  <= '0;
            on_q     <= 1'b0;
            to_cnt_q <= TO_LOAD;
            mk_q     <= '0;
            k1_q     <= '0;
            disp_q   <= '0;
        end else begin
            state_q  <= state_d;
            sh_min_q <= sh_min_d;
            sh_hr_q  <= sh_hr_d;
            cm_min_q <= cm_min_d;
            cm_hr_q  <= cm_hr_d;
            on_q     <= on_d;
            to_cnt_q <= to_cnt_d;
            mk_q     <= mk_d;
            k1_q     <= k1_d;
            disp_q   <= disp_d;
        end
    end

    assign mk       = mk_q;
    assign k1       = k1_q;
    assign f        = disp_q[15:12];
    assign e        = disp_q[11:8];
    assign d        = disp_q[7:4];
    assign c        = disp_q[3:0];
    assign alarm_on = on_q;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Scoreboard bench for alarm_set_ctrl: stimulus pushes expected output words, a negedge monitor pops
// one entry per observed output change and compares value and, where given, the cycle of the change.
module tb_alarm_set_ctrl;
    localparam int DB = 4;
    localparam int TO = 64;
    localparam int RD = 16;
    localparam int RP = 8;

    logic       fs = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_sel = 1'b0;
    logic       key_inc = 1'b0;
    logic [1:0] mk, k1;
    logic [3:0] c, d, e, f;
    logic       alarm_on;
    logic [20:0] dut_val;

    alarm_set_ctrl #(
        .DB_CYCLES(DB), .TIMEOUT_CYCLES(TO), .REPEAT_DLY(RD), .REPEAT_PER(RP)
    ) dut (
        .fs(fs), .rst_n(rst_n), .key_mode(key_mode), .key_sel(key_sel), .key_inc(key_inc),
        .mk(mk), .k1(k1), .c(c), .d(d), .e(e), .f(f), .alarm_on(alarm_on)
    );

    always #5 fs = ~fs;

    int cyc = 0;
    always @(posedge fs) cyc <= cyc + 1;

    assign dut_val = {mk, k1, f, e, d, c, alarm_on};

    int n_vec = 0;
    int n_err = 0;

    logic [20:0] ev_q[$];
    int          ec_q[$];
    string       en_q[$];

    // reference model: state 0 idle, 1 minutes, 2 hours; times kept as plain integers
    int   m_state = 0;
    int   m_cmin = 0, m_chr = 0, m_smin = 0, m_shr = 0;
    logic m_on = 1'b0;

    function automatic logic [20:0] model_val();
        int mn, hr;
        logic [1:0] mk_e, k1_e;
        if (m_state == 0) begin
            mn = m_cmin; hr = m_chr; mk_e = 2'b00; k1_e = 2'b00;
        end else begin
            mn = m_smin; hr = m_shr; mk_e = 2'b11;
            k1_e = (m_state == 2) ? 2'b01 : 2'b00;
        end
        return {mk_e, k1_e, 4'(hr / 10), 4'(hr % 10), 4'(mn / 10), 4'(mn % 10), m_on};
    endfunction

    task automatic expect_out(input string name, input int at_cyc);
        ev_q.push_back(model_val());
        ec_q.push_back(at_cyc);
        en_q.push_back(name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge fs);
    endtask

    task automatic check_now(input string name);
        logic [20:0] exp_v;
        exp_v = model_val();
        n_vec++;
        if (dut_val !== exp_v) begin
            n_err++;
            $display("FAIL %s got=%h required=%h", name, dut_val, exp_v);
        end
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0: key_mode = v;
            1: key_sel  = v;
            default: key_inc = v;
        endcase
    endtask

    task automatic hit(input int k);
        @(negedge fs);
        set_key(k, 1'b1);
        tick(DB + 4);
        set_key(k, 1'b0);
        tick(DB + 4);
    endtask

    task automatic press_mode(input string name);
        if (m_state == 0) begin
            m_state = 1; m_smin = m_cmin; m_shr = m_chr;
        end else begin
            m_cmin = m_smin; m_chr = m_shr; m_state = 0;
        end
        expect_out(name, -1);
        hit(0);
    endtask

    task automatic press_sel(input string name);
        if (m_state != 0) begin
            m_state = (m_state == 1) ? 2 : 1;
            expect_out(name, -1);
        end
        hit(1);
    endtask

    task automatic press_inc(input string name);
        if (m_state == 0) m_on = ~m_on;
        else if (m_state == 1) m_smin = (m_smin + 1) % 60;
        else m_shr = (m_shr + 1) % 24;
        expect_out(name, -1);
        hit(2);
    endtask

    // monitor: any change of the output word must match the oldest pending expectation
    logic [20:0] prev_v = '0;
    logic        mon_en = 1'b0;
    always @(negedge fs) begin
        logic [20:0] xv;
        int          xc;
        string       xn;
        if (mon_en && dut_val !== prev_v) begin
            n_vec++;
            if (ev_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_change got=%h required=no change at cyc=%0d", dut_val, cyc);
            end else begin
                xv = ev_q.pop_front();
                xc = ec_q.pop_front();
                xn = en_q.pop_front();
                if (dut_val !== xv || (xc >= 0 && cyc != xc)) begin
                    n_err++;
                    $display("FAIL %s got=%h required=%h cyc=%0d required_cyc=%0d",
                             xn, dut_val, xv, cyc, xc);
                end
            end
        end
        prev_v = dut_val;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check_now("reset_init");
        mon_en = 1'b1;
        tick(2);

        // bouncing mode key, then a clean hold: one press, mk=11 seven cycles after last edge
        @(negedge fs);
        for (int i = 0; i < 6; i++) begin
            key_mode = ~key_mode;
            tick(2);
        end
        key_mode = 1'b1;
        m_state = 1; m_smin = m_cmin; m_shr = m_chr;
        expect_out("bounce_press_latency", cyc + DB + 3);
        tick(DB + 4);
        key_mode = 1'b0;
        tick(DB + 4);

        // minute wrap without carry into hours
        for (int i = 0; i < 59; i++) press_inc("min_inc");
        check_now("min_at_59");
        press_inc("min_wrap_59_00");
        press_mode("commit_00_00");

        // 3-cycle glitch on inc in IDLE must not toggle alarm_on
        @(negedge fs);
        key_inc = 1'b1;
        tick(3);
        key_inc = 1'b0;
        tick(DB + 6);
        check_now("glitch_no_press");

        press_inc("idle_inc_alarm_on");
        press_sel("idle_sel");
        check_now("idle_sel_ignored");

        // hour wrap and commit of 07:00
        press_mode("enter_set");
        press_sel("sel_to_hour");
        for (int i = 0; i < 23; i++) press_inc("hr_inc");
        check_now("hr_at_23");
        press_inc("hr_wrap_23_00");
        for (int i = 0; i < 7; i++) press_inc("hr_inc_to_7");
        press_mode("commit_07_00");

        // timeout discards the shadow edit
        press_mode("enter_set_to");
        for (int i = 0; i < 5; i++) press_inc("min_inc_to");
        m_state = 0;
        expect_out("timeout_to_idle", -1);
        tick(TO + 24);
        check_now("after_timeout");

        // same-cycle mode+inc in IDLE: mode wins, alarm_on kept
        @(negedge fs);
        m_state = 1; m_smin = m_cmin; m_shr = m_chr;
        expect_out("mode_inc_same_cycle", -1);
        key_mode = 1'b1;
        key_inc  = 1'b1;
        tick(DB + 4);
        key_mode = 1'b0;
        key_inc  = 1'b0;
        tick(DB + 4);
        check_now("alarm_on_kept");

        // held inc in SET_MIN
        @(negedge fs);
        key_inc = 1'b1;
        k0 = cyc;
`ifdef AUTO_REPEAT_EN
        for (int i = 0; i < 5; i++) begin
            m_smin = (m_smin + 1) % 60;
            expect_out("repeat_inc", k0 + DB + 3 + ((i == 0) ? 0 : RD + (i - 1) * RP));
        end
`else
        m_smin = (m_smin + 1) % 60;
        expect_out("held_inc_single", k0 + DB + 3);
`endif
        tick(DB + 3 + 38);
        key_inc = 1'b0;
        tick(DB + 8);
        check_now("after_hold");

        // asynchronous reset in the middle of an edit
        @(posedge fs);
        #2;
        m_state = 0; m_cmin = 0; m_chr = 0; m_smin = 0; m_shr = 0; m_on = 1'b0;
        expect_out("reset_mid_run", -1);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check_now("reset_state");
        press_inc("post_reset_alarm_on");
        press_mode("post_reset_enter");
        press_mode("post_reset_commit");

        tick(10);
        n_vec++;
        if (ev_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_pending got=%0d required=0", ev_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
